pwl_segment_sampler: RTL and testbench
======================================

Name: pwl_segment_sampler

Overview:
- Clocked reader for the PWL segment stream produced by the event-driven filter/source cells.
- Accepts fixed-point segments (offset a, slope b, start time t0) through a valid/ready handshake and buffers them in a small FIFO.
- Activates each segment when its start time is reached and evaluates y = a + b*(t - t0) on a free-running tick counter.
- Sits at the analog-model/digital boundary; feeds sampled PWL values into synchronous logic (ADC back-ends, checkers).

Parameters:
AW, 16, signed width of segment offset and of the sampled output
BW, 16, signed width of segment slope (LSB per tick, FRAC fractional bits)
FRAC, 8, fractional bits of the slope
TW, 24, width of tick counter and segment start time
DEPTH, 4, segment FIFO depth (power of 2, >= 2)

Ports:
clk  in  1  sampling clock; one tick per rising edge
rstn  in  1  asynchronous active-low reset
seg_valid  in  1  segment offered
seg_ready  out  1  FIFO can accept a segment
seg_a  in  AW  segment offset (signed)
seg_b  in  BW  segment slope (signed, Q.FRAC per tick)
seg_t  in  TW  segment start tick
sample_en  in  1  request a sample this cycle
y_out  out  AW  sampled value (signed, saturated)
y_valid  out  1  y_out updated this cycle
active  out  1  a current segment is loaded
sat  out  1  sticky: saturation occurred since reset

Behaviour:
- Reset (rstn low, async): tnow=0, FIFO empty, no current segment, y_out=0, y_valid=0, active=0, sat=0, seg_ready=0 while in reset and 1 on the first cycle after release.
- tnow increments by 1 each clock and wraps modulo 2^TW. All time comparisons use the signed TW-bit difference d = head.t - tnow. A segment is "due" when d <= 0.
- Push: occurs when seg_valid && seg_ready. seg_ready = !full and is registered; it does not depend on a same-cycle pop. When full, no push occurs even if a pop happens that cycle.
- Pop/activate: when the FIFO is non-empty and the head is due, the head is loaded into the current-segment registers (cur_a, cur_b, cur_t) and popped. At most one activation per cycle, so consecutive due segments activate on successive cycles, each overwriting the last. active goes high on the first activation and stays high until reset.
- A segment pushed with a past start time is still activated. Elapsed time is computed from its own t0, not from the activation time.
- Elapsed e = tnow - cur_t, taken as a signed TW-bit value and clamped to the range [0, 2^(TW-1)-1].
- Evaluation: p = cur_b * e at full width (BW+TW bits). Shift p arithmetically right by FRAC. Compute y = cur_a + shifted p at full width, then saturate to the signed AW range. Saturation sets sat.
- Sample: on the cycle after sample_en is high, y_out holds the value computed from the state at the sample_en edge (latency 1) and y_valid pulses for one cycle.
- If active=0 at sample time: y_out=0, y_valid=1.
- Activation and sample in the same cycle: the sample uses the segment that was current before the activation.
- Push into an empty FIFO in the same cycle the segment is due: the segment activates no earlier than the next cycle.

Optional Feature:
- Macro PWL_SAMPLER_DEADBAND_EN.
- Defined: adds parameter ETOL (default 4, unsigned, AW-1 bits) and a register holding the last reported value. y_valid and the y_out update occur only when:
  - |y - last| >= ETOL, or
  - an activation occurred since the last report, or
  - this is the first sample after reset.
  Otherwise y_out holds its value and y_valid stays 0.
- Undefined: every sample_en produces a y_valid pulse, and neither ETOL nor the register exists.

Test Plan:
- Reset release, sample_en held high, no segments -> y_valid every cycle with y_out=0, active=0, seg_ready=1.
- Push a=100, b=256 (1.0/tick), t=10; sample at tnow=15 -> y_out=105 next cycle; active rose at tnow=10 (+1 cycle registration).
- Fill 4 segments with t=50,50,50,60 -> seg_ready=0 after the 4th push. Activations occur at ticks 50, 51, 52, 60, in FIFO order.
- a=32767, b=256, t=0 -> y_out=32767 after tick 1, and sat=1 sticky. Also a=-32768, b=-256 -> y_out=-32768.
- TW=8 wrap: tnow=250, push t=4 -> activates after wrap at tnow=4, not immediately. Push t=240 at tnow=250 -> activates at once, and the sample reads a + 10*b.
- Assert rstn mid-stream with 3 segments queued -> all outputs return to reset values asynchronously, FIFO empty, tnow restarts at 0. With PWL_SAMPLER_DEADBAND_EN and ETOL=4, b=256: y_valid pulses every 4th sample.

Source files
------------

// File: rtl/pwl_segment_sampler.sv
// -----------------------------------------------------------------------------
// pwl_segment_sampler
//
// Clocked reader for a piecewise-linear (PWL) segment stream. Segments
// (offset a, slope b in Q.FRAC per tick, start tick t0) are accepted through a
// valid/ready handshake into a small FIFO. A free-running tick counter tnow
// decides when the FIFO head becomes current. On request, the current segment
// is evaluated as y = a + ((b * (tnow - t0)) >>> FRAC), saturated to AW bits.
//
// Ports:
//   clk        sampling clock, one tick per rising edge
//   rstn       asynchronous active-low reset
//   seg_valid  segment offered
//   seg_ready  FIFO can accept a segment (registered, equals !full)
//   seg_a      segment offset (signed, AW bits)
//   seg_b      segment slope (signed, BW bits, FRAC fractional bits per tick)
//   seg_t      segment start tick (TW bits, compared modulo 2^TW)
//   sample_en  request a sample this cycle
//   y_out      sampled value (signed, saturated), valid one cycle after request
//   y_valid    y_out updated this cycle
//   active     a current segment has been loaded since reset
//   sat        sticky flag: a sample saturated since reset
//
// Optional feature (macro PWL_SAMPLER_DEADBAND_EN):
//   Adds parameter ETOL. A sample is only reported (y_valid pulse and y_out
//   update) when it differs from the last reported value by at least ETOL,
//   when a segment was activated since the last report, or when it is the
//   first sample after reset. Without the macro every sample is reported.
// -----------------------------------------------------------------------------
module pwl_segment_sampler #(
    parameter int AW    = 16,
    parameter int BW    = 16,
    parameter int FRAC  = 8,
    parameter int TW    = 24,
    parameter int DEPTH = 4
`ifdef PWL_SAMPLER_DEADBAND_EN
    ,
    parameter logic [AW-2:0] ETOL = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 seg_valid,
    output logic                 seg_ready,
    input  logic signed [AW-1:0] seg_a,
    input  logic signed [BW-1:0] seg_b,
    input  logic        [TW-1:0] seg_t,
    input  logic                 sample_en,
    output logic signed [AW-1:0] y_out,
    output logic                 y_valid,
    output logic                 active,
    output logic                 sat
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int PW   = BW + TW;
    localparam int YW   = ((AW > PW) ? AW : PW) + 1;

    localparam logic [PTRW:0]          FULL_CNT = (PTRW+1)'(DEPTH);
    localparam logic signed [YW-1:0]   Y_MAX    = {{(YW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [YW-1:0]   Y_MIN    = {{(YW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    // Saturation helpers for the full-width evaluation result.
    function automatic logic ovf_fn(input logic signed [YW-1:0] v);
        return (v > Y_MAX) || (v < Y_MIN);
    endfunction

    function automatic logic signed [AW-1:0] sat_fn(input logic signed [YW-1:0] v);
        if (v > Y_MAX) begin
            return Y_MAX[AW-1:0];
        end else if (v < Y_MIN) begin
            return Y_MIN[AW-1:0];
        end
        return v[AW-1:0];
    endfunction

    // ---------------- state ----------------
    logic signed [AW-1:0] fifo_a_q [DEPTH];
    logic signed [BW-1:0] fifo_b_q [DEPTH];
    logic        [TW-1:0] fifo_t_q [DEPTH];

    logic [PTRW-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [PTRW-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [PTRW:0]        count_q,     count_d;
    logic                 seg_ready_q, seg_ready_d;
    logic [TW-1:0]        tnow_q,      tnow_d;
    logic                 active_q,    active_d;
    logic                 sat_q,       sat_d;
    logic signed [AW-1:0] y_out_q,     y_out_d;
    logic                 y_valid_q,   y_valid_d;

    logic signed [AW-1:0] cur_a_q;
    logic signed [BW-1:0] cur_b_q;
    logic        [TW-1:0] cur_t_q;

`ifdef PWL_SAMPLER_DEADBAND_EN
    logic                 first_q,     first_d;
    logic                 act_seen_q,  act_seen_d;
    logic signed [AW:0]   db_diff;
    logic        [AW:0]   db_mag;
`endif

    // ---------------- combinational datapath ----------------
    logic                 push;
    logic                 pop;
    logic                 report;
    logic signed [TW-1:0] due_diff;
    logic signed [TW-1:0] elapsed_raw;
    logic signed [TW-1:0] elapsed;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic signed [YW-1:0] a_ext;
    logic signed [YW-1:0] y_full;
    logic signed [AW-1:0] y_calc;
    logic                 y_ovf;

    // Signed modular difference so that start times survive tnow wrap-around.
    assign due_diff    = fifo_t_q[rd_ptr_q] - tnow_q;
    assign elapsed_raw = tnow_q - cur_t_q;
    // A negative elapsed time (segment older than half the counter range) clamps to 0.
    assign elapsed     = elapsed_raw[TW-1] ? '0 : elapsed_raw;
    assign prod        = cur_b_q * elapsed;
    assign prod_sh     = prod >>> FRAC;
    assign a_ext       = cur_a_q;
    assign y_full      = a_ext + prod_sh;
    assign y_calc      = active_q ? sat_fn(y_full) : '0;
    assign y_ovf       = active_q && ovf_fn(y_full);

`ifdef PWL_SAMPLER_DEADBAND_EN
    // y_out_q only changes on a report, so it is the last reported value.
    assign db_diff = {y_calc[AW-1], y_calc} - {y_out_q[AW-1], y_out_q};
    assign db_mag  = db_diff[AW] ? $unsigned(-db_diff) : $unsigned(db_diff);
    assign report  = first_q || act_seen_q || (db_mag >= {2'b00, ETOL});
`else
    assign report  = 1'b1;
`endif

    always_comb begin
        push = seg_valid && seg_ready_q;
        // Head is due when its start tick is at or before tnow.
        pop  = (count_q != '0) && (due_diff[TW-1] || (due_diff == '0));

        wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTRW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (PTRW+1)'(1);
        end

        // Registered ready reflects the post-update occupancy.
        seg_ready_d = (count_d != FULL_CNT);
        tnow_d      = tnow_q + TW'(1);
        active_d    = active_q || pop;

        // Sample uses the segment that was current before any same-cycle activation.
        y_valid_d = 1'b0;
        y_out_d   = y_out_q;
        sat_d     = sat_q;
        if (sample_en) begin
            if (report) begin
                y_valid_d = 1'b1;
                y_out_d   = y_calc;
            end
            if (y_ovf) begin
                sat_d = 1'b1;
            end
        end

`ifdef PWL_SAMPLER_DEADBAND_EN
        first_d    = first_q && !(sample_en && report);
        // An activation after a same-cycle report must still force the next report.
        act_seen_d = pop ? 1'b1 : (act_seen_q && !(sample_en && report));
`endif
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seg_ready_q <= 1'b0;
            tnow_q      <= '0;
            active_q    <= 1'b0;
            sat_q       <= 1'b0;
            y_out_q     <= '0;
            y_valid_q   <= 1'b0;
`ifdef PWL_SAMPLER_DEADBAND_EN
            first_q     <= 1'b1;
            act_seen_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seg_ready_q <= seg_ready_d;
            tnow_q      <= tnow_d;
            active_q    <= active_d;
            sat_q       <= sat_d;
            y_out_q     <= y_out_d;
            y_valid_q   <= y_valid_d;
`ifdef PWL_SAMPLER_DEADBAND_EN
            first_q     <= first_d;
            act_seen_q  <= act_seen_d;
`endif
        end
    end

    // ---------------- segment storage (data, no reset) ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= seg_a;
            fifo_b_q[wr_ptr_q] <= seg_b;
            fifo_t_q[wr_ptr_q] <= seg_t;
        end
    end

    // Current segment is only meaningful once active is set.
    always_ff @(posedge clk) begin
        if (pop) begin
            cur_a_q <= fifo_a_q[rd_ptr_q];
            cur_b_q <= fifo_b_q[rd_ptr_q];
            cur_t_q <= fifo_t_q[rd_ptr_q];
        end
    end

    assign seg_ready = seg_ready_q;
    assign y_out     = y_out_q;
    assign y_valid   = y_valid_q;
    assign active    = active_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_pwl_segment_sampler.sv
// -----------------------------------------------------------------------------
// tb_pwl_segment_sampler
//
// Bench for pwl_segment_sampler built with an 8-bit tick counter so that
// wrap-around is reached quickly. A behavioural model (segment queue, integer
// arithmetic, floor division) predicts every output after each clock.
// -----------------------------------------------------------------------------
module tb_pwl_segment_sampler;

    localparam int AW = 16, BW = 16, FRAC = 8, TW = 8, DEPTH = 4;
    localparam int TMOD = 256;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 seg_valid;
    logic                 seg_ready;
    logic signed [AW-1:0] seg_a;
    logic signed [BW-1:0] seg_b;
    logic        [TW-1:0] seg_t;
    logic                 sample_en;
    logic signed [AW-1:0] y_out;
    logic                 y_valid;
    logic                 active;
    logic                 sat;

    pwl_segment_sampler #(
        .AW(AW), .BW(BW), .FRAC(FRAC), .TW(TW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .seg_valid(seg_valid), .seg_ready(seg_ready),
        .seg_a(seg_a), .seg_b(seg_b), .seg_t(seg_t),
        .sample_en(sample_en),
        .y_out(y_out), .y_valid(y_valid), .active(active), .sat(sat)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // Reference model state
    int q_a[$], q_b[$], q_t[$];
    int m_tnow, c_a, c_b, c_t, m_y;
    bit m_active, m_sat, m_ready, m_yv, m_first, m_actseen;

    function automatic int wrap_signed(input int v);
        int r;
        r = v & (TMOD - 1);
        if (r >= TMOD / 2) r -= TMOD;
        return r;
    endfunction

    function automatic longint floor_div256(input longint p);
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    // Unsaturated value of the current segment at the current tick.
    function automatic longint model_raw_y();
        int e;
        e = (m_tnow - c_t) & (TMOD - 1);
        if (e >= TMOD / 2) e = 0;
        return longint'(c_a) + floor_div256(longint'(c_b) * e);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y_valid"},   32'(y_valid),   32'(m_yv));
        check({tag, ".y_out"},     32'(y_out),     32'(m_y));
        check({tag, ".active"},    32'(active),    32'(m_active));
        check({tag, ".sat"},       32'(sat),       32'(m_sat));
        check({tag, ".seg_ready"}, 32'(seg_ready), 32'(m_ready));
    endtask

    task automatic model_reset();
        q_a.delete(); q_b.delete(); q_t.delete();
        m_tnow = 0; m_y = 0; m_yv = 0;
        m_active = 0; m_sat = 0; m_ready = 0;
        m_first = 1; m_actseen = 0;
        c_a = 0; c_b = 0; c_t = 0;
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step(input string tag);
        bit     push, act, ovf, rep;
        longint raw;
        int     y;
        @(posedge clk);
        push = seg_valid && m_ready;
        act  = (q_a.size() > 0) && (wrap_signed(q_t[0] - m_tnow) <= 0);
        m_yv = 0;
        if (sample_en) begin
            y = 0; ovf = 0;
            if (m_active) begin
                raw = model_raw_y();
                if (raw > 32767)       begin y = 32767;  ovf = 1; end
                else if (raw < -32768) begin y = -32768; ovf = 1; end
                else                         y = int'(raw);
            end
`ifdef PWL_SAMPLER_DEADBAND_EN
            rep = m_first || m_actseen || ((y > m_y ? y - m_y : m_y - y) >= 4);
`else
            rep = 1;
`endif
            if (rep) begin
                m_yv = 1; m_y = y; m_first = 0; m_actseen = 0;
            end
            if (ovf) m_sat = 1;
        end
        if (act) begin
            c_a = q_a.pop_front(); c_b = q_b.pop_front(); c_t = q_t.pop_front();
            m_active = 1; m_actseen = 1;
        end
        if (push) begin
            q_a.push_back(int'(seg_a)); q_b.push_back(int'(seg_b)); q_t.push_back(int'(seg_t));
        end
        m_tnow  = (m_tnow + 1) & (TMOD - 1);
        m_ready = (q_a.size() < DEPTH);
        #1;
        check_all(tag);
    endtask

    task automatic offer(input int a, input int b, input int t);
        seg_valid = 1'b1;
        seg_a = AW'(a); seg_b = BW'(b); seg_t = TW'(t);
    endtask

    task automatic run_until(input int target, input string tag);
        for (int i = 0; i < 2 * TMOD && m_tnow != target; i++) step(tag);
        check({tag, ".reached"}, 32'(m_tnow), 32'(target));
    endtask

    initial begin
        rstn = 1'b0; seg_valid = 1'b0; sample_en = 1'b0;
        seg_a = '0; seg_b = '0; seg_t = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rstn = 1'b1;

        // Idle sampling with no segments.
        sample_en = 1'b1;
        repeat (3) step("idle");

        // Single segment a=100, b=1.0/tick, t0=10; sample at tick 15.
        sample_en = 1'b0;
        offer(100, 256, 10);
        step("seg1_push");
        seg_valid = 1'b0;
        run_until(15, "seg1_wait");
        sample_en = 1'b1;
        step("seg1_sample");
        check("seg1_y105", 32'(y_out), 32'(105));

        // Fill the FIFO; flat segments expose which one is current.
        offer(1, 0, 50); step("fill1");
        offer(2, 0, 50); step("fill2");
        offer(3, 0, 50); step("fill3");
        offer(4, 0, 60); step("fill4");
        check("fill_ready_low", 32'(seg_ready), 32'(0));
        seg_valid = 1'b0;
        run_until(62, "fill_drain");
        check("fill_last_a", 32'(y_out), 32'(4));

        // Positive and negative saturation.
        offer(32767, 256, m_tnow); step("satp_push");
        seg_valid = 1'b0;
        repeat (5) step("satp_run");
        check("satp_y", 32'(y_out), 32'(32767));
        check("satp_sticky", 32'(sat), 32'(1));
        offer(-32768, -256, m_tnow); step("satn_push");
        seg_valid = 1'b0;
        repeat (5) step("satn_run");
        check("satn_y", 32'(y_out), 32'(-32768));

        // Asynchronous reset with three far-future segments queued.
        for (int i = 0; i < 3; i++) begin
            offer(10 + i, 256, m_tnow + 100); step("mid_queue");
        end
        seg_valid = 1'b0;
        #2 rstn = 1'b0;
        model_reset();
        #1 check_all("mid_reset_async");
        repeat (3) @(posedge clk);
        #1 check_all("mid_reset_hold");
        @(negedge clk) rstn = 1'b1;
        sample_en = 1'b1;
        repeat (3) step("post_reset");
        offer(1, 0, 2); step("post_reset_push");
        seg_valid = 1'b0;
        repeat (4) step("post_reset_run");

        // Start tick beyond the wrap must wait; a past start tick activates at once.
        run_until(250, "wrap_adv1");
        offer(7, 256, 4); step("wrap_future_push");
        seg_valid = 1'b0;
        run_until(8, "wrap_future_run");
        run_until(250, "wrap_adv2");
        offer(5, 256, 240); step("wrap_past_push");
        seg_valid = 1'b0;
        run_until(255, "wrap_past_run");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            seg_valid = ($urandom_range(0, 2) == 0);
            seg_a     = AW'($urandom);
            seg_b     = ($urandom_range(0, 3) == 0) ? BW'($urandom)
                                                    : BW'(int'($urandom_range(0, 2048)) - 1024);
            seg_t     = TW'(m_tnow + int'($urandom_range(0, 60)) - 20);
            sample_en = $urandom_range(0, 1) == 1;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
